pulse_stretch_queue: RTL and testbench
======================================

# pulse_stretch_queue

Converts single-cycle pulses into level windows: each pulse on `pulse_in` produces a `level_out` HIGH window of fixed length, followed by a mandatory LOW gap. This is the pulse-to-level counterpart of the button debouncer/one-shot. Pulses that arrive while a window is playing out are counted and replayed in order. It sits in the `clk_oled` domain between the debounced button pulses and downstream level consumers such as LEDs, a buzzer enable, or OLED highlight flags.

## Interface
- `HIGH_CYCLES`, default 16: length of each HIGH window in cycles; must be >= 1.
- `GAP_CYCLES`, default 4: forced LOW cycles after every window; must be >= 1.
- `PEND_W`, default 3: width of the pending counter; maximum queued pulses = 2^PEND_W - 1.
- `clk_oled`, input, 1: sole clock; everything is updated on the rising edge.
- `reset_n`, input, 1: asynchronous reset, active-low. Clears all state immediately.
- `pulse_in`, input, 1: request pulse, sampled every edge. Each HIGH cycle counts as one request.
- `clear`, input, 1: synchronous flush. Highest priority after `reset_n`.
- `level_out`, output, 1: registered stretched level.
- `busy`, output, 1: registered; HIGH while state is HIGH or GAP.
- `pending`, output, PEND_W: registered count of queued, not-yet-started windows.
- `overflow`, output, 1: sticky; set when a pulse is dropped; cleared only by `reset_n` or `clear`.

## Operation
- **Reset values:** state IDLE, phase counter 0, `level_out`=0, `busy`=0, `pending`=0, `overflow`=0.
- **FSM states:** IDLE, HIGH, GAP.
  - In HIGH, `level_out`=1. In IDLE and GAP, `level_out`=0.
  - `busy` = (state != IDLE).
- **Phase counter:** width $clog2 of max(HIGH_CYCLES, GAP_CYCLES), minimum 1 bit. It reloads to 0 on every state entry.
- **IDLE:**
  - `pulse_in`=1 -> HIGH.
  - `pending` is unchanged.
- **HIGH:**
  - Stays for exactly HIGH_CYCLES cycles.
  - On the last cycle (count = HIGH_CYCLES-1) -> GAP.
- **GAP:**
  - Stays for exactly GAP_CYCLES cycles.
  - On the last cycle, let `want` = (`pending` != 0) | `pulse_in`.
  - `want`=1 -> HIGH, with `pending` <= `pending` + `pulse_in` - 1.
  - `want`=0 -> IDLE.
- **Queuing:** a `pulse_in` in HIGH, or in GAP outside the last-cycle decision, does `pending` <= `pending` + 1.
- **Saturation:**
  - If `pending` = 2^PEND_W - 1 and a pulse arrives that is not consumed by a decision that same cycle, the pulse is dropped, `pending` holds, and `overflow` <= 1.
  - At the GAP decision, a pulse arriving with `pending` saturated is a net +0: `pending` holds and no overflow is flagged.
- **Ordering:** queued windows are identical, so only the count is stored; there is no per-pulse data.
- **`clear`=1:**
  - Next state is IDLE; `level_out`, `pending` and `overflow` go to 0.
  - A `pulse_in` in the same cycle is ignored.
  - A window in progress is truncated.
- **`reset_n` low mid-window:** `level_out` drops to 0 without waiting for an edge. All registers hold reset values until `reset_n` rises. The first edge after release behaves as IDLE.

## Timing
- **Latency:** a pulse sampled at edge T (IDLE) gives `level_out`=1 for cycles T+1 .. T+HIGH_CYCLES, then 0 for the next GAP_CYCLES cycles.
- **Queued throughput:** one window per HIGH_CYCLES + GAP_CYCLES cycles. There is no extra IDLE cycle between queued windows.
- **IDLE re-entry:** occurs at cycle T + HIGH_CYCLES + GAP_CYCLES + 1. A pulse there starts a new window on the following cycle.
- **Registered outputs:** `pending` and `overflow` update on the same edge as the triggering `pulse_in`.
- **Paths:** no combinational path from any input to any output.

## Test plan
All scenarios use HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
- **Reset values:** hold `reset_n`=0 for 3 cycles while toggling `pulse_in` -> all outputs 0 throughout. After release with no pulse, outputs stay 0.
- **Single pulse:** pulse at cycle 10 -> `level_out`=1 for cycles 11-14, 0 for 15-16; `busy`=1 for 11-16; IDLE from 17; `pending` stays 0.
- **Queued pulses:** pulses at cycles 10, 12, 13 -> HIGH windows at 11-14, 17-20, 23-26; `pending` reads 1 at 13, 2 at 14, 1 at 17, 0 at 23; `overflow` stays 0.
- **Overflow:** pulses on every cycle 10-14 -> `pending` saturates at 3 by cycle 14; the pulse at cycle 14 sets `overflow`=1 from 15; exactly 4 windows, starting at 11, 17, 23, 29; `overflow` still 1 after drain.
- **Gap-edge pulse:** a single pulse at cycle 10, then another at cycle 16 (the last GAP cycle, `pending`=0) -> second window at 17-20 with no IDLE cycle; `pending` never leaves 0.
- **Flush and async reset:**
  - `clear` at cycle 12 during the window from scenario 3 -> `level_out`=0, `pending`=0, `busy`=0 from cycle 13; no further windows.
  - Separately, `reset_n` low at mid-cycle 12 -> `level_out` falls before the next edge.

Source files
------------

// File: rtl/pulse_stretch_queue.sv
// Pulse-to-level stretcher: each request pulse becomes a HIGH window of HIGH_CYCLES
// followed by a GAP_CYCLES low gap; pulses arriving mid-window are counted and replayed.
module pulse_stretch_queue #(
    parameter int HIGH_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int PEND_W      = 3
) (
    input  logic              clk_oled,
    input  logic              reset_n,
    input  logic              pulse_in,
    input  logic              clear,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]     HIGH_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              level_q, level_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk_oled or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (pulse_in) begin
                    if (pending_q == PEND_MAX) overflow_d = 1'b1;
                    else                       pending_d  = pending_q + PEND_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    // Decision cycle: a pulse here is consumed directly, never dropped.
                    cnt_d = '0;
                    if (pulse_in) begin
                        state_d = ST_HIGH;
                    end else if (pending_q != '0) begin
                        state_d   = ST_HIGH;
                        pending_d = pending_q - PEND_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (pulse_in) begin
                        if (pending_q == PEND_MAX) overflow_d = 1'b1;
                        else                       pending_d  = pending_q + PEND_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (clear) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            pending_d  = '0;
            overflow_d = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        level_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_stretch_queue.sv
// Directed bench for pulse_stretch_queue with HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
module tb_pulse_stretch_queue;

  localparam int NCYC = 40;
  localparam int NSCEN = 6;

  logic       clk_oled = 1'b0;
  logic       reset_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic       clear = 1'b0;
  logic       level_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  pulse_stretch_queue #(
    .HIGH_CYCLES(4),
    .GAP_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .clk_oled (clk_oled),
    .reset_n  (reset_n),
    .pulse_in (pulse_in),
    .clear    (clear),
    .level_out(level_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk_oled = ~clk_oled;

  // A scenario: pulse cycles, optional clear cycle, expected window starts,
  // pending change points (value holds from that cycle on) and overflow start.
  typedef struct {
    string       name;
    logic [NCYC-1:0] pulses;
    int          clr;
    int          st[4];
    int          nst;
    int          pc[6];
    int          pv[6];
    int          np;
    int          ovf_from;
  } scen_t;

  scen_t scen[NSCEN];

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  // driver: hold reset for 3 cycles while toggling pulse_in, release at a negedge
  task automatic do_reset();
    @(negedge clk_oled);
    reset_n = 1'b0;
    clear = 1'b0;
    pulse_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_oled);
      #1;
      check("rst_level", i, 32'(level_out), 0);
      check("rst_busy", i, 32'(busy), 0);
      check("rst_pending", i, 32'(pending), 0);
      check("rst_overflow", i, 32'(overflow), 0);
      pulse_in = ~pulse_in;
    end
    @(negedge clk_oled);
    pulse_in = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic run_scen(input int k);
    logic exp_lvl, exp_bsy, exp_ovf;
    int exp_pend;
    do_reset();
    for (int c = 0; c < NCYC; c++) begin
      exp_lvl = 1'b0;
      exp_bsy = 1'b0;
      for (int s = 0; s < scen[k].nst; s++) begin
        if (c >= scen[k].st[s] && c <= scen[k].st[s] + 3) exp_lvl = 1'b1;
        if (c >= scen[k].st[s] && c <= scen[k].st[s] + 5) exp_bsy = 1'b1;
      end
      exp_pend = 0;
      for (int p = 0; p < scen[k].np; p++)
        if (c >= scen[k].pc[p]) exp_pend = scen[k].pv[p];
      exp_ovf = (scen[k].ovf_from >= 0) && (c >= scen[k].ovf_from);
      if (scen[k].clr >= 0 && c > scen[k].clr) begin
        exp_lvl = 1'b0;
        exp_bsy = 1'b0;
        exp_pend = 0;
        exp_ovf = 1'b0;
      end
      check({scen[k].name, "_level"}, c, 32'(level_out), 32'(exp_lvl));
      check({scen[k].name, "_busy"}, c, 32'(busy), 32'(exp_bsy));
      check({scen[k].name, "_pending"}, c, 32'(pending), 32'(exp_pend));
      check({scen[k].name, "_overflow"}, c, 32'(overflow), 32'(exp_ovf));
      pulse_in = scen[k].pulses[c];
      clear = (c == scen[k].clr);
      @(negedge clk_oled);
    end
    pulse_in = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NSCEN; k++) begin
      scen[k].pulses = '0;
      scen[k].clr = -1;
      scen[k].nst = 0;
      scen[k].np = 0;
      scen[k].ovf_from = -1;
      for (int j = 0; j < 4; j++) scen[k].st[j] = 0;
      for (int j = 0; j < 6; j++) begin
        scen[k].pc[j] = 0;
        scen[k].pv[j] = 0;
      end
    end

    scen[0].name = "single";
    scen[0].pulses[10] = 1'b1;
    scen[0].st[0] = 11; scen[0].nst = 1;

    scen[1].name = "queued";
    scen[1].pulses[10] = 1'b1; scen[1].pulses[12] = 1'b1; scen[1].pulses[13] = 1'b1;
    scen[1].st[0] = 11; scen[1].st[1] = 17; scen[1].st[2] = 23; scen[1].nst = 3;
    scen[1].pc[0] = 13; scen[1].pv[0] = 1;
    scen[1].pc[1] = 14; scen[1].pv[1] = 2;
    scen[1].pc[2] = 17; scen[1].pv[2] = 1;
    scen[1].pc[3] = 23; scen[1].pv[3] = 0;
    scen[1].np = 4;

    scen[2].name = "overflow";
    for (int c = 10; c <= 14; c++) scen[2].pulses[c] = 1'b1;
    scen[2].st[0] = 11; scen[2].st[1] = 17; scen[2].st[2] = 23; scen[2].st[3] = 29;
    scen[2].nst = 4;
    scen[2].pc[0] = 12; scen[2].pv[0] = 1;
    scen[2].pc[1] = 13; scen[2].pv[1] = 2;
    scen[2].pc[2] = 14; scen[2].pv[2] = 3;
    scen[2].pc[3] = 17; scen[2].pv[3] = 2;
    scen[2].pc[4] = 23; scen[2].pv[4] = 1;
    scen[2].pc[5] = 29; scen[2].pv[5] = 0;
    scen[2].np = 6;
    scen[2].ovf_from = 15;

    scen[3].name = "gap_edge";
    scen[3].pulses[10] = 1'b1; scen[3].pulses[16] = 1'b1;
    scen[3].st[0] = 11; scen[3].st[1] = 17; scen[3].nst = 2;

    scen[4].name = "clear_mid";
    scen[4].pulses[10] = 1'b1; scen[4].pulses[11] = 1'b1; scen[4].pulses[12] = 1'b1;
    scen[4].clr = 12;
    scen[4].st[0] = 11; scen[4].nst = 1;
    scen[4].pc[0] = 12; scen[4].pv[0] = 1;
    scen[4].np = 1;

    scen[5].name = "clear_ovf";
    for (int c = 10; c <= 14; c++) scen[5].pulses[c] = 1'b1;
    scen[5].clr = 20;
    scen[5].st[0] = 11; scen[5].st[1] = 17; scen[5].nst = 2;
    scen[5].pc[0] = 12; scen[5].pv[0] = 1;
    scen[5].pc[1] = 13; scen[5].pv[1] = 2;
    scen[5].pc[2] = 14; scen[5].pv[2] = 3;
    scen[5].pc[3] = 17; scen[5].pv[3] = 2;
    scen[5].np = 4;
    scen[5].ovf_from = 15;

    for (int k = 0; k < NSCEN; k++) run_scen(k);

    // Async reset in the middle of cycle 12 of a window started by a pulse at 10.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      pulse_in = (c == 10);
      @(negedge clk_oled);
    end
    pulse_in = 1'b0;
    check("async_pre_level", 12, 32'(level_out), 1);
    check("async_pre_busy", 12, 32'(busy), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_level", 12, 32'(level_out), 0);
    check("async_busy", 12, 32'(busy), 0);
    @(negedge clk_oled);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("async_after_level", c, 32'(level_out), 0);
      check("async_after_state", c, 32'(dbg_state), 0);
      @(negedge clk_oled);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
